// File: rtl/bitmask_rightmost_bit_iterator.sv
// Walks the set bits of an accepted bitmask from LSB to MSB, emitting one beat per set bit
// (or a single "none" beat for an all-zero word) over a valid/ready stream.
module bitmask_rightmost_bit_iterator #(
  parameter int WORD_WIDTH  = 8,
  parameter int INDEX_WIDTH = 3,
  parameter int OUTPUT_MODE = 0
) (
  input  logic                   clock,
  input  logic                   clear_n,
  input  logic [WORD_WIDTH-1:0]  word_in,
  input  logic                   word_in_valid,
  output logic                   word_in_ready,
  output logic [WORD_WIDTH-1:0]  word_out,
  output logic [INDEX_WIDTH-1:0] index_out,
  output logic                   last_out,
  output logic                   none_out,
  output logic                   word_out_valid,
  input  logic                   word_out_ready
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [WORD_WIDTH-1:0]  r_remaining;
  logic [WORD_WIDTH-1:0]  w_remaining_next;
  logic [WORD_WIDTH-1:0]  w_rem_minus1;
  logic [WORD_WIDTH-1:0]  w_rem_cleared;
  logic [INDEX_WIDTH-1:0] w_index;
  logic                   w_iter;
  logic                   w_last;
  logic                   w_in_hs;
  logic                   w_out_hs;

  // Modulo subtraction: a zero remaining wraps to all ones, which the formulas rely on.
  assign w_rem_minus1  = r_remaining - 1'b1;
  assign w_rem_cleared = r_remaining & w_rem_minus1;

  assign w_iter   = (r_state == ST_ITER);
  assign w_last   = (w_rem_cleared == '0);
  assign w_in_hs  = word_in_valid & word_in_ready;
  assign w_out_hs = word_out_valid & word_out_ready;

  generate
    if (OUTPUT_MODE == 1) begin : g_thermo
      assign word_out = r_remaining ^ w_rem_minus1;
    end else begin : g_onehot
      assign word_out = r_remaining & ~w_rem_minus1;
    end
  endgenerate

  // Scanning downward leaves the lowest set bit as the final winner.
  always_comb begin
    w_index = '0;
    for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
      if (r_remaining[i]) w_index = INDEX_WIDTH'(i);
    end
  end

  assign index_out      = w_index;
  assign word_out_valid = w_iter;
  assign last_out       = w_iter & w_last;
  assign none_out       = w_iter & (r_remaining == '0);
  assign word_in_ready  = w_iter ? (w_last & word_out_ready) : 1'b1;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    if (w_in_hs) begin
      w_state_next     = ST_ITER;
      w_remaining_next = word_in;
    end else if (w_out_hs) begin
      if (w_last) w_state_next = ST_IDLE;
      else        w_remaining_next = w_rem_cleared;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
    end
  end

endmodule

// File: tb/tb_bitmask_rightmost_bit_iterator.sv
// Scoreboard bench: mode-0 and mode-1 instances share stimulus; expected beats are derived
// from the set bits of each accepted word and popped by an independent monitor.
module tb_bitmask_rightmost_bit_iterator;

  logic       clock = 1'b0;
  logic       clear_n = 1'b0;
  logic [7:0] word_in = '0;
  logic       word_in_valid = 1'b0;
  logic       word_out_ready = 1'b0;

  logic       ready0, ready1, valid0, valid1, last0, last1, none0, none1;
  logic [7:0] word0, word1;
  logic [2:0] index0, index1;

  bitmask_rightmost_bit_iterator #(.WORD_WIDTH(8), .INDEX_WIDTH(3), .OUTPUT_MODE(0)) dut0 (
    .clock(clock), .clear_n(clear_n), .word_in(word_in), .word_in_valid(word_in_valid),
    .word_in_ready(ready0), .word_out(word0), .index_out(index0), .last_out(last0),
    .none_out(none0), .word_out_valid(valid0), .word_out_ready(word_out_ready));

  bitmask_rightmost_bit_iterator #(.WORD_WIDTH(8), .INDEX_WIDTH(3), .OUTPUT_MODE(1)) dut1 (
    .clock(clock), .clear_n(clear_n), .word_in(word_in), .word_in_valid(word_in_valid),
    .word_in_ready(ready1), .word_out(word1), .index_out(index1), .last_out(last1),
    .none_out(none1), .word_out_valid(valid1), .word_out_ready(word_out_ready));

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] onehot;
    logic [7:0] thermo;
    logic [2:0] idx;
    logic       last;
    logic       none;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: one beat per set bit in ascending order; an empty word yields a single none beat.
  task automatic push_word(input logic [7:0] w);
    int hi;
    beat_t b;
    if (w == 8'd0) begin
      b = '{onehot: 8'h00, thermo: 8'hFF, idx: 3'd0, last: 1'b1, none: 1'b1};
      exp_q.push_back(b);
    end else begin
      hi = 0;
      for (int i = 0; i < 8; i++) if (w[i]) hi = i;
      for (int i = 0; i < 8; i++) begin
        if (w[i]) begin
          b.onehot = 8'(32'd1 << i);
          b.thermo = 8'((32'd1 << (i + 1)) - 1);
          b.idx    = 3'(i);
          b.last   = (i == hi);
          b.none   = 1'b0;
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // Monitor: sees only beats for words accepted at earlier edges.
  always @(negedge clock) begin : monitor
    beat_t b;
    bit    have;
    have = (exp_q.size() != 0);
    check("valid_m0", valid0, have);
    check("valid_m1", valid1, have);
    if (have) begin
      b = exp_q[0];
      check("word_m0", word0, b.onehot);
      check("word_m1", word1, b.thermo);
      check("index_m0", index0, b.idx);
      check("index_m1", index1, b.idx);
      check("last", last0, b.last);
      check("none", none0, b.none);
      check("in_ready_iter_m0", ready0, b.last & word_out_ready);
      check("in_ready_iter_m1", ready1, b.last & word_out_ready);
      if (word_out_ready) void'(exp_q.pop_front());
    end else begin
      check("last_idle", last0 | last1, 0);
      check("none_idle", none0 | none1, 0);
      check("in_ready_idle", {ready1, ready0}, 2'b11);
    end
  end

  task automatic step(output bit hs);
    bit         rst;
    logic [7:0] w;
    @(negedge clock);
    hs  = clear_n && word_in_valid && ready0;
    rst = !clear_n;
    w   = word_in;
    @(posedge clock);
    if (rst) exp_q.delete();
    else if (hs) push_word(w);
    #1;
  endtask

  task automatic idle(input int n);
    bit hs;
    word_in_valid = 1'b0;
    repeat (n) step(hs);
  endtask

  task automatic send(input logic [7:0] w, output int cycles);
    bit hs;
    word_in       = w;
    word_in_valid = 1'b1;
    cycles        = 0;
    hs            = 1'b0;
    while (!hs && cycles < 64) begin
      step(hs);
      cycles++;
    end
    if (!hs) check("send_timeout", 0, 1);
    word_in_valid = 1'b0;
  endtask

  initial begin : stimulus
    bit hs;
    int cyc;

    repeat (2) step(hs);
    check("reset_word_m0", word0, 8'h00);
    check("reset_word_m1", word1, 8'hFF);
    check("reset_index", index0, 0);
    clear_n        = 1'b1;
    word_out_ready = 1'b1;
    idle(2);

    send(8'b0101_1000, cyc); idle(5);
    send(8'b0000_0000, cyc); idle(3);

    word_out_ready = 1'b0;
    send(8'b1000_0001, cyc);
    idle(3);
    word_out_ready = 1'b1;
    idle(4);

    send(8'b0000_0010, cyc);
    send(8'b0000_0100, cyc);
    check("b2b_accept_cycles", cyc, 1);
    idle(3);

    send(8'b1111_0000, cyc);
    step(hs);
    clear_n = 1'b0;
    step(hs);
    clear_n = 1'b1;
    check("mid_reset_valid", valid0, 0);
    check("mid_reset_ready", ready0, 1);
    idle(4);

    for (int c = 0; c < 3000; c++) begin
      word_in        = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      word_in_valid  = ($urandom_range(0, 9) < 7);
      word_out_ready = ($urandom_range(0, 9) < 7);
      clear_n        = ($urandom_range(0, 199) != 0);
      step(hs);
    end

    clear_n        = 1'b1;
    word_in_valid  = 1'b0;
    word_out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 64) begin
      step(hs);
      cyc++;
    end
    idle(2);
    check("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bitmask_rightmost_bit_iterator.md
BITMASK_RIGHTMOST_BIT_ITERATOR -- requirements
Module: bitmask_rightmost_bit_iterator

Interface
REQ-001 Parameter WORD_WIDTH, default 8: bitmask width in bits; SHALL be >= 2.
REQ-002 Parameter INDEX_WIDTH, default 3: width of index_out; SHALL be >= clog2(WORD_WIDTH).
REQ-003 Parameter OUTPUT_MODE, default 0: selects the word_out format. 0 = one-hot of the rightmost 1 bit. 1 = thermometer of the rightmost 1 bit and its trailing 0s.
REQ-004 clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 clear_n  input  1  reset, synchronous and active-low.
REQ-006 word_in  input  WORD_WIDTH  bitmask to iterate.
REQ-007 word_in_valid  input  1  word_in is offered.
REQ-008 word_in_ready  output  1  block accepts word_in this cycle.
REQ-009 word_out  output  WORD_WIDTH  current beat, formatted per OUTPUT_MODE.
REQ-010 index_out  output  INDEX_WIDTH  bit position of the current rightmost 1 bit; 0 if none.
REQ-011 last_out  output  1  current beat is the final beat for this word.
REQ-012 none_out  output  1  accepted word was all zeros.
REQ-013 word_out_valid  output  1  beat is presented.
REQ-014 word_out_ready  input  1  consumer takes the beat.

Function
REQ-015 Internal state SHALL be two states, IDLE and ITER, plus a WORD_WIDTH-bit register "remaining".
REQ-016 In IDLE: word_in_ready=1 and word_out_valid=0.
REQ-017 In ITER: word_out_valid=1.
REQ-018 Input handshake = word_in_valid & word_in_ready. On it: remaining <= word_in; state <= ITER.
REQ-019 Output handshake = word_out_valid & word_out_ready.
REQ-020 Latency: the first beat of an accepted word SHALL be valid in the cycle after the input handshake.
REQ-021 OUTPUT_MODE 0: word_out SHALL equal remaining & ~(remaining - 1).
REQ-022 OUTPUT_MODE 1: word_out SHALL equal remaining ^ (remaining - 1).
REQ-023 Both formulas use modulo-2^WORD_WIDTH subtraction. A zero remaining therefore yields all ones in mode 1 and all zeros in mode 0.
REQ-024 last_out SHALL equal ((remaining & (remaining - 1)) == 0) while in ITER; otherwise 0.
REQ-025 none_out SHALL equal (remaining == 0) while in ITER; otherwise 0.
REQ-026 On an output handshake with last_out=0: remaining <= remaining & (remaining - 1), clearing exactly the rightmost 1 bit.
REQ-027 On an output handshake with last_out=1: state <= IDLE, unless REQ-029 applies.
REQ-028 Without an output handshake, remaining and all outputs SHALL hold stable (backpressure).
REQ-029 In ITER, word_in_ready SHALL equal last_out & word_out_ready. A simultaneous last-beat handshake and input handshake loads the new word and stays in ITER, with no bubble.
REQ-030 A zero word SHALL produce exactly one beat: none_out=1, last_out=1, index_out=0.
REQ-031 A word with N set bits SHALL produce exactly N beats, in ascending bit order.
REQ-032 word_in_valid while word_in_ready=0 SHALL be ignored; no data is captured.

Reset
REQ-033 While clear_n=0 at a rising edge: state <= IDLE and remaining <= 0, overriding any simultaneous handshake.
REQ-034 After reset: word_out_valid=0, word_in_ready=1, last_out=0, none_out=0.
REQ-035 After reset, word_out and index_out SHALL be don't-care but deterministic (formula applied to remaining=0).
REQ-036 Reset mid-iteration SHALL discard all remaining beats.

Verification (WORD_WIDTH=8, word_out_ready=1 unless stated)
REQ-037 Mode 0, word_in 01011000 accepted at cycle N: SHALL give three beats.
- Cycle N+1: word_out 00001000, index_out 3.
- Cycle N+2: word_out 00010000, index_out 4.
- Cycle N+3: word_out 01000000, index_out 6, last_out=1.
- Cycle N+4: word_out_valid=0.
REQ-038 Mode 1, same stimulus: SHALL give word_out 00001111, then 00011111, then 01111111 (last_out=1).
REQ-039 Zero word 00000000: SHALL give one beat with none_out=1 and last_out=1; word_out 00000000 in mode 0, 11111111 in mode 1.
REQ-040 Backpressure: word_in 10000001 with word_out_ready=0 for 3 cycles SHALL hold word_out 00000001 and index_out 0 stable.
- After ready rises: word_out 10000000, index_out 7, last_out=1.
REQ-041 Back-to-back: word_in 00000010 then 00000100, word_in_valid held high.
- Second word SHALL be accepted on the cycle of the first word's only beat.
- Beat 00000100 SHALL appear in the following cycle, with no idle cycle.
REQ-042 Reset mid-iteration: word_in 11110000; clear_n=0 for one cycle after the first beat.
- Next cycle SHALL show word_out_valid=0 and word_in_ready=1.
- No further beats for that word.
